// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM boundary bundle: EX-side instruction fields plus the
// registered MEM-side bundle and redirect outputs of ex_mem_stage.
interface ex_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_alu_c_i;
    logic            ex_zero_i;
    logic [XLEN-1:0] ex_imm_i;
    logic [XLEN-1:0] ex_rs2_i;
    logic [4:0]      ex_rd_i;
    logic            ex_reg_write_i;
    logic            ex_mem_read_i;
    logic            ex_mem_write_i;
    logic            ex_branch_i;
    logic            ex_jal_i;
    logic            ex_jalr_i;
    logic            ex_ready_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            misalign_o;
    logic            mem_valid_o;
    logic [XLEN-1:0] mem_result_o;
    logic [XLEN-1:0] mem_rs2_o;
    logic [4:0]      mem_rd_o;
    logic            mem_reg_write_o;
    logic            mem_mem_read_o;
    logic            mem_mem_write_o;

    modport master (
        output ex_valid_i, ex_pc_i, ex_alu_c_i, ex_zero_i, ex_imm_i,
        output ex_rs2_i, ex_rd_i, ex_reg_write_i, ex_mem_read_i,
        output ex_mem_write_i, ex_branch_i, ex_jal_i, ex_jalr_i,
        input  ex_ready_o, redirect_o, redirect_pc_o, misalign_o,
        input  mem_valid_o, mem_result_o, mem_rs2_o, mem_rd_o,
        input  mem_reg_write_o, mem_mem_read_o, mem_mem_write_o
    );

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_alu_c_i, ex_zero_i, ex_imm_i,
        input  ex_rs2_i, ex_rd_i, ex_reg_write_i, ex_mem_read_i,
        input  ex_mem_write_i, ex_branch_i, ex_jal_i, ex_jalr_i,
        output ex_ready_o, redirect_o, redirect_pc_o, misalign_o,
        output mem_valid_o, mem_result_o, mem_rs2_o, mem_rd_o,
        output mem_reg_write_o, mem_mem_read_o, mem_mem_write_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution and redirect.
// Optional branch statistics counters: define EXMEM_BRSTATS_EN.
module ex_mem_stage #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          mem_stall_i,
    input  logic          flush_i,
    ex_mem_stage_if.slave bus
`ifdef EXMEM_BRSTATS_EN
    ,
    input  logic          stats_clr_i,
    output logic [31:0]   br_taken_cnt_o,
    output logic [31:0]   br_nt_cnt_o
`endif
);
    logic            acc;
    logic            taken;
    logic            mis;
    logic            link;
    logic [XLEN-1:0] target;

    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic            rw_q, rw_d;
    logic            mr_q, mr_d;
    logic            mw_q, mw_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;

    // Reset is folded in so no redirect escapes while the stage is reset.
    always_comb begin
        acc    = bus.ex_valid_i & ~mem_stall_i & ~flush_i & rstn;
        taken  = (bus.ex_branch_i & bus.ex_zero_i)
               | bus.ex_jal_i | bus.ex_jalr_i;
        link   = bus.ex_jal_i | bus.ex_jalr_i;
        target = bus.ex_pc_i + bus.ex_imm_i;
        if (bus.ex_jalr_i) begin
            target = {bus.ex_alu_c_i[XLEN-1:1], 1'b0};
        end
        mis    = taken & target[1];
    end

    assign bus.ex_ready_o    = ~mem_stall_i;
    assign bus.redirect_o    = acc & taken & ~mis;
    assign bus.redirect_pc_o = bus.redirect_o ? target : '0;

    always_comb begin
        valid_d  = valid_q;
        mis_d    = mis_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        result_d = result_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        if (flush_i) begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
        end else if (!mem_stall_i) begin
            valid_d = acc;
            mis_d   = acc & mis;
            rw_d    = acc & ~mis & bus.ex_reg_write_i;
            mr_d    = acc & ~mis & bus.ex_mem_read_i;
            mw_d    = acc & ~mis & bus.ex_mem_write_i;
            if (acc) begin
                rs2_d = bus.ex_rs2_i;
                rd_d  = bus.ex_rd_i;
                // A branch's C is only its condition, so it is not kept.
                if (link) begin
                    result_d = bus.ex_pc_i + XLEN'(4);
                end else if (!bus.ex_branch_i) begin
                    result_d = bus.ex_alu_c_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            result_q <= RESET_PC_LINK;
            rs2_q    <= '0;
            rd_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            mis_q    <= mis_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            result_q <= result_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.mem_valid_o     = valid_q;
    assign bus.misalign_o      = mis_q;
    assign bus.mem_reg_write_o = rw_q & valid_q;
    assign bus.mem_mem_read_o  = mr_q & valid_q;
    assign bus.mem_mem_write_o = mw_q & valid_q;
    assign bus.mem_result_o    = result_q;
    assign bus.mem_rs2_o       = rs2_q;
    assign bus.mem_rd_o        = rd_q;

`ifdef EXMEM_BRSTATS_EN
    logic [31:0] tk_cnt_q, tk_cnt_d;
    logic [31:0] nt_cnt_q, nt_cnt_d;

    always_comb begin
        tk_cnt_d = tk_cnt_q;
        nt_cnt_d = nt_cnt_q;
        if (stats_clr_i) begin
            tk_cnt_d = '0;
            nt_cnt_d = '0;
        end else if (acc && bus.ex_branch_i) begin
            if (bus.ex_zero_i) begin
                if (tk_cnt_q != '1) tk_cnt_d = tk_cnt_q + 32'd1;
            end else begin
                if (nt_cnt_q != '1) nt_cnt_d = nt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tk_cnt_q <= '0;
            nt_cnt_q <= '0;
        end else begin
            tk_cnt_q <= tk_cnt_d;
            nt_cnt_q <= nt_cnt_d;
        end
    end

    assign br_taken_cnt_o = tk_cnt_q;
    assign br_nt_cnt_o    = nt_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage against a behavioural
// model of the MEM-stage contents and the same-cycle redirect.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic mem_stall_i = 1'b0;
    logic flush_i = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;

    ex_mem_stage_if bus ();

`ifdef EXMEM_BRSTATS_EN
    logic        stats_clr_i = 1'b0;
    logic [31:0] br_taken_cnt_o;
    logic [31:0] br_nt_cnt_o;
    longint      m_tk = 0;
    longint      m_nt = 0;
`endif

    ex_mem_stage dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem_stall_i (mem_stall_i),
        .flush_i     (flush_i),
        .bus         (bus)
`ifdef EXMEM_BRSTATS_EN
        ,
        .stats_clr_i   (stats_clr_i),
        .br_taken_cnt_o(br_taken_cnt_o),
        .br_nt_cnt_o   (br_nt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Model of what MEM must hold.
    bit          e_valid = 0, e_mis = 0, e_rw = 0, e_mr = 0, e_mw = 0;
    logic [31:0] e_res = 0, e_rs2 = 0;
    logic [4:0]  e_rd = 0;

    function automatic logic [31:0] tgt_of();
        if (bus.ex_jalr_i) return bus.ex_alu_c_i & 32'hFFFF_FFFE;
        return bus.ex_pc_i + bus.ex_imm_i;
    endfunction

    function automatic bit taken_of();
        return (bus.ex_branch_i && bus.ex_zero_i) || bus.ex_jal_i || bus.ex_jalr_i;
    endfunction

    function automatic bit bad_of();
        return taken_of() && (tgt_of() % 4 != 0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            e_valid = 0; e_mis = 0; e_rw = 0; e_mr = 0; e_mw = 0;
            e_res = 0; e_rs2 = 0; e_rd = 0;
        end else if (flush_i) begin
            e_valid = 0; e_mis = 0;
        end else if (!mem_stall_i) begin
            if (bus.ex_valid_i) begin
                e_valid = 1;
                e_mis = bad_of();
                e_rw = !e_mis && bus.ex_reg_write_i;
                e_mr = !e_mis && bus.ex_mem_read_i;
                e_mw = !e_mis && bus.ex_mem_write_i;
                e_rs2 = bus.ex_rs2_i;
                e_rd = bus.ex_rd_i;
                if (bus.ex_jal_i || bus.ex_jalr_i) e_res = bus.ex_pc_i + 4;
                else if (!bus.ex_branch_i) e_res = bus.ex_alu_c_i;
            end else begin
                e_valid = 0; e_mis = 0;
            end
        end
`ifdef EXMEM_BRSTATS_EN
        if (!rstn || stats_clr_i) begin
            m_tk = 0; m_nt = 0;
        end else if (bus.ex_valid_i && !mem_stall_i && !flush_i && bus.ex_branch_i) begin
            if (bus.ex_zero_i) m_tk = (m_tk == 64'hFFFF_FFFF) ? m_tk : m_tk + 1;
            else m_nt = (m_nt == 64'hFFFF_FFFF) ? m_nt : m_nt + 1;
        end
`endif
    end

    always @(negedge clk) begin
        if (armed) begin
            bit          rd_exp;
            logic [31:0] pc_exp;
            rd_exp = rstn && bus.ex_valid_i && !mem_stall_i && !flush_i
                   && taken_of() && !bad_of();
            pc_exp = rd_exp ? tgt_of() : 32'h0;
            check("ex_ready", 32'(bus.ex_ready_o), 32'(!mem_stall_i));
            check("redirect", 32'(bus.redirect_o), 32'(rd_exp));
            check("redirect_pc", bus.redirect_pc_o, pc_exp);
            check("mem_valid", 32'(bus.mem_valid_o), 32'(e_valid));
            check("misalign", 32'(bus.misalign_o), 32'(e_mis));
            check("reg_write", 32'(bus.mem_reg_write_o), 32'(e_valid && e_rw));
            check("mem_read", 32'(bus.mem_mem_read_o), 32'(e_valid && e_mr));
            check("mem_write", 32'(bus.mem_mem_write_o), 32'(e_valid && e_mw));
            if (e_valid) begin
                check("result", bus.mem_result_o, e_res);
                check("rs2", bus.mem_rs2_o, e_rs2);
                check("rd", 32'(bus.mem_rd_o), 32'(e_rd));
            end
`ifdef EXMEM_BRSTATS_EN
            check("taken_cnt", br_taken_cnt_o, m_tk[31:0]);
            check("nt_cnt", br_nt_cnt_o, m_nt[31:0]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid_i = 0; bus.ex_pc_i = 0; bus.ex_alu_c_i = 0;
        bus.ex_zero_i = 0; bus.ex_imm_i = 0; bus.ex_rs2_i = 0;
        bus.ex_rd_i = 0; bus.ex_reg_write_i = 0; bus.ex_mem_read_i = 0;
        bus.ex_mem_write_i = 0; bus.ex_branch_i = 0; bus.ex_jal_i = 0;
        bus.ex_jalr_i = 0;
    endtask

    task automatic branch(logic [31:0] pc, logic [31:0] imm, bit z);
        idle();
        bus.ex_valid_i = 1; bus.ex_pc_i = pc; bus.ex_imm_i = imm;
        bus.ex_zero_i = z; bus.ex_branch_i = 1; bus.ex_alu_c_i = 32'(!z);
    endtask

    initial begin
        idle();
        step();
        step();
        armed = 1;
        check("rst_valid", 32'(bus.mem_valid_o), 32'h0);
        check("rst_result", bus.mem_result_o, 32'h0);
        rstn = 1;

        // BNE taken
        branch(32'h100, 32'h20, 1);
        #1;
        check("bne_redirect", 32'(bus.redirect_o), 32'h1);
        check("bne_target", bus.redirect_pc_o, 32'h120);
        step();
        idle();
        check("bne_valid", 32'(bus.mem_valid_o), 32'h1);
        check("bne_rw", 32'(bus.mem_reg_write_o), 32'h0);

        // branch not taken
        branch(32'h100, 32'h20, 0);
        #1;
        check("bnt_redirect", 32'(bus.redirect_o), 32'h0);
        step();
        idle();
        check("bnt_valid", 32'(bus.mem_valid_o), 32'h1);

        // JALR with link
        bus.ex_valid_i = 1; bus.ex_pc_i = 32'h200; bus.ex_alu_c_i = 32'h1235;
        bus.ex_rd_i = 1; bus.ex_reg_write_i = 1; bus.ex_jalr_i = 1;
        #1;
        check("jalr_redirect", 32'(bus.redirect_o), 32'h1);
        check("jalr_target", bus.redirect_pc_o, 32'h1234);
        step();
        idle();
        check("jalr_link", bus.mem_result_o, 32'h204);
        check("jalr_rd", 32'(bus.mem_rd_o), 32'h1);
        check("jalr_rw", 32'(bus.mem_reg_write_o), 32'h1);

        // JAL misaligned
        bus.ex_valid_i = 1; bus.ex_pc_i = 32'h0; bus.ex_imm_i = 32'h6;
        bus.ex_rd_i = 1; bus.ex_reg_write_i = 1; bus.ex_jal_i = 1;
        #1;
        check("jal_mis_redirect", 32'(bus.redirect_o), 32'h0);
        step();
        idle();
        check("jal_misalign", 32'(bus.misalign_o), 32'h1);
        check("jal_mis_rw", 32'(bus.mem_reg_write_o), 32'h0);

        // load, then stall with a taken branch waiting, then flush
        bus.ex_valid_i = 1; bus.ex_alu_c_i = 32'h40; bus.ex_rd_i = 5;
        bus.ex_reg_write_i = 1; bus.ex_mem_read_i = 1;
        step();
        branch(32'h300, 32'h8, 1);
        mem_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(bus.ex_ready_o), 32'h0);
            check("stall_redirect", 32'(bus.redirect_o), 32'h0);
            check("stall_valid", 32'(bus.mem_valid_o), 32'h1);
            check("stall_read", 32'(bus.mem_mem_read_o), 32'h1);
            check("stall_result", bus.mem_result_o, 32'h40);
            step();
        end
        flush_i = 1;
        step();
        flush_i = 0; mem_stall_i = 0;
        idle();
        check("flush_valid", 32'(bus.mem_valid_o), 32'h0);
        check("flush_read", 32'(bus.mem_mem_read_o), 32'h0);

        // reset mid-operation
        bus.ex_valid_i = 1; bus.ex_alu_c_i = 32'h77; bus.ex_rs2_i = 32'h99;
        bus.ex_rd_i = 7; bus.ex_reg_write_i = 1;
        step();
        branch(32'h400, 32'h10, 1);
        rstn = 0;
        #1;
        check("rst_redirect", 32'(bus.redirect_o), 32'h0);
        step();
        rstn = 1;
        idle();
        check("rst2_valid", 32'(bus.mem_valid_o), 32'h0);
        check("rst2_result", bus.mem_result_o, 32'h0);
        check("rst2_rs2", bus.mem_rs2_o, 32'h0);
        check("rst2_rd", 32'(bus.mem_rd_o), 32'h0);
        check("rst2_mis", 32'(bus.misalign_o), 32'h0);

`ifdef EXMEM_BRSTATS_EN
        for (int i = 0; i < 8; i++) begin
            branch(32'h500, 32'h4, i < 5);
            step();
        end
        idle();
        check("cnt_taken", br_taken_cnt_o, 32'd5);
        check("cnt_nt", br_nt_cnt_o, 32'd3);
        stats_clr_i = 1;
        step();
        stats_clr_i = 0;
        check("clr_taken", br_taken_cnt_o, 32'd0);
        check("clr_nt", br_nt_cnt_o, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            int k;
            k = $urandom_range(0, 3);
            idle();
            bus.ex_valid_i = $urandom_range(0, 9) < 8;
            bus.ex_pc_i = $urandom & 32'hFFFF_FFFC;
            bus.ex_imm_i = $urandom & 32'hFFFF_FFFE;
            bus.ex_alu_c_i = $urandom;
            bus.ex_zero_i = $urandom_range(0, 1) == 1;
            bus.ex_rs2_i = $urandom;
            bus.ex_rd_i = 5'($urandom_range(0, 31));
            bus.ex_reg_write_i = $urandom_range(0, 1) == 1;
            bus.ex_branch_i = k == 1;
            bus.ex_jal_i = k == 2;
            bus.ex_jalr_i = k == 3;
            if (k == 0) begin
                bus.ex_mem_read_i = $urandom_range(0, 2) == 0;
                bus.ex_mem_write_i = $urandom_range(0, 2) == 0;
            end
            mem_stall_i = $urandom_range(0, 4) == 0;
            flush_i = $urandom_range(0, 19) == 0;
            rstn = $urandom_range(0, 49) != 0;
`ifdef EXMEM_BRSTATS_EN
            stats_clr_i = $urandom_range(0, 29) == 0;
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register plus branch/jump resolution. Sits directly downstream of the EX-stage ALU.
- Consumes the ALU result C and Zero flag together with EX-stage control.
- Produces the registered MEM-stage bundle, a one-cycle fetch redirect for taken branches and jumps, and a misaligned-target exception.
- Owns the stall/flush/bubble behaviour of the EX->MEM boundary.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_LINK, 0, reset value of the mem_result_o register.

Ports:
- clk input 1 — rising-edge clock.
- rstn input 1 — synchronous, active-low reset.
- ex_valid_i input 1 — EX holds a live instruction.
- ex_pc_i input 32 — PC of the EX instruction.
- ex_alu_c_i input 32 — ALU result C.
- ex_zero_i input 1 — ALU Zero flag (C==0).
- ex_imm_i input 32 — sign-extended branch/JAL offset.
- ex_rs2_i input 32 — store data, already forwarded.
- ex_rd_i input 5 — destination register.
- ex_reg_write_i input 1 — writes rd.
- ex_mem_read_i input 1 — load.
- ex_mem_write_i input 1 — store.
- ex_branch_i input 1 — conditional branch.
- ex_jal_i input 1 — JAL.
- ex_jalr_i input 1 — JALR.
- mem_stall_i input 1 — MEM cannot accept; hold register.
- flush_i input 1 — kill the EX/MEM contents (trap from later stage).
- ex_ready_o output 1 — EX instruction accepted this cycle (= !mem_stall_i).
- redirect_o output 1 — fetch redirect pulse (combinational).
- redirect_pc_o output 32 — redirect target.
- misalign_o output 1 — registered exception: taken target not word-aligned.
- mem_valid_o output 1 — MEM holds a live instruction.
- mem_result_o output 32 — ALU result, or link address for JAL/JALR.
- mem_rs2_o output 32 — store data.
- mem_rd_o output 5 — destination register.
- mem_reg_write_o output 1 — register write enable (qualified by valid).
- mem_mem_read_o output 1 — load enable (qualified by valid).
- mem_mem_write_o output 1 — store enable (qualified by valid).

Behaviour:
- Accept: acc = ex_valid_i & !mem_stall_i & !flush_i.
- Branch condition:
  - The ALU branch ops return the negated condition in C[0], so a conditional branch is taken iff ex_zero_i == 1.
  - The ALU result of a conditional branch is never forwarded to mem_result_o.
- taken = ex_branch_i & ex_zero_i | ex_jal_i | ex_jalr_i.
- Target:
  - branch/JAL: target = ex_pc_i + ex_imm_i, mod 2^32, wrap-around allowed.
  - JALR: target = {ex_alu_c_i[31:1],1'b0}.
- Misalignment: mis = taken & target[1].
- Redirect:
  - redirect_o = acc & taken & !mis; redirect_pc_o = target.
  - Asserted at most once per instruction, never during a stall cycle, never under flush_i.
  - redirect_pc_o = 0 when redirect_o = 0.
- Register update, priority rstn > flush_i > mem_stall_i > load:
  - rstn=0: mem_valid_o=0, all control outputs 0, mem_result_o=RESET_PC_LINK, mem_rs2_o=0, mem_rd_o=0, misalign_o=0.
  - flush_i=1: mem_valid_o<=0 and misalign_o<=0; data registers may hold. Flush wins over a simultaneous stall.
  - mem_stall_i=1: all registers hold, including misalign_o.
  - Otherwise: mem_valid_o<=acc; misalign_o<=acc & mis.
  - Data load on acc: mem_result_o <= (jal|jalr) ? ex_pc_i+4 : ex_alu_c_i.
  - If !ex_valid_i and not stalled: a bubble is loaded (mem_valid_o<=0).
- Misaligned instruction: enters MEM with mem_reg_write_o=0, mem_mem_read_o=0, mem_mem_write_o=0.
- Control outputs: mem_reg_write_o/mem_mem_read_o/mem_mem_write_o are registered AND mem_valid_o; never 1 when mem_valid_o=0.
- Latency: one cycle EX->MEM; redirect is zero-cycle, same cycle as accept.
- Reset mid-stall: reset wins; stage empties and no redirect is issued.

Optional Feature:
- Macro: EXMEM_BRSTATS_EN.
- Defined: adds
  - output br_taken_cnt_o 32
  - output br_nt_cnt_o 32
  - input stats_clr_i 1
- Counters:
  - On acc & ex_branch_i, increment the taken or not-taken counter.
  - Counters saturate at 32'hFFFFFFFF.
  - stats_clr_i or rstn=0 zeroes both; clear wins over a simultaneous increment.
  - JAL/JALR are not counted.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- BNE taken, no stall:
  - Stimulus: ex_pc=0x100, imm=0x20, ex_zero=1, ex_branch=1, valid=1.
  - Same cycle: redirect_o=1, redirect_pc_o=0x120.
  - Next cycle: mem_valid_o=1, mem_reg_write_o=0.
- Branch not taken:
  - Stimulus: ex_zero=0.
  - redirect_o=0; stage loads with mem_valid_o=1.
- JALR with link:
  - Stimulus: ex_pc=0x200, alu_c=0x1235, rd=1, reg_write=1.
  - redirect_pc_o=0x1234.
  - Next cycle: mem_result_o=0x204, mem_rd_o=1, mem_reg_write_o=1.
- JAL misaligned target:
  - Stimulus: ex_pc=0x0, imm=0x6.
  - redirect_o=0.
  - Next cycle: misalign_o=1, mem_reg_write_o=0.
- Stall then flush:
  - Hold a load with mem_stall_i=1 for 3 cycles: outputs constant, ex_ready_o=0, no redirect from a taken branch in EX during the stall.
  - Then flush_i=1 together with mem_stall_i=1: next cycle mem_valid_o=0, mem_mem_read_o=0.
- Reset mid-operation:
  - Stimulus: rstn=0 while mem_valid_o=1 and a taken branch sits in EX.
  - Next cycle: all outputs at reset values, mem_result_o=RESET_PC_LINK.
  - With EXMEM_BRSTATS_EN: 5 taken + 3 not-taken branches give counts 5/3, then stats_clr_i gives 0/0.
